neo_frame_sequencer: RTL

Sequences the NEO energy engine frame by frame.
- Accepts an incoming sample stream with valid/ready handshake and writes exactly M samples into the engine's input sample RAM.
- Releases the engine from reset to run one NEO pass, waits for the engine's ready pulse, reports frame completion, then loops.
- Arbitrates the single sample RAM: the sequencer writes only while the engine is held in reset, so writer and engine reader never overlap.

---
 rtl/neo_pkg.sv | 27 ++
 rtl/neo_run_watchdog.sv | 40 ++++
 rtl/neo_frame_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/neo_pkg.sv
//==============================================================================
// Module      : neo_pkg
// Description : Shared state encoding and timing constants for the NEO frame
//               sequencer and its run watchdog.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package neo_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        KICK = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } neo_seq_state_t;

    // Slack beyond the frame depth before a silent engine is declared hung
    localparam int NEO_TIMEOUT_MARGIN = 8;
    // The engine raises ready this many cycles beyond M after release
    localparam int NEO_ENG_LATENCY    = 2;

endpackage

`default_nettype wire

// File: rtl/neo_run_watchdog.sv
//==============================================================================
// Module      : neo_run_watchdog
// Description : Counts cycles spent in RUN and pulses timeout on the cycle the
//               count would reach M + NEO_TIMEOUT_MARGIN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module neo_run_watchdog
    import neo_pkg::*;
#(
    parameter int M = 32
) (
    input  logic Clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int            W      = $clog2(M) + 1;
    localparam logic [W-1:0]  c_last = W'(M + NEO_TIMEOUT_MARGIN - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge Clk) begin
        if (!reset || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires while the counter sits at the last legal run cycle, so the FSM
    // lands in ERR exactly when the count would hit the limit
    assign timeout = enable && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/neo_frame_sequencer.sv
//==============================================================================
// Module      : neo_frame_sequencer
// Description : Fills the NEO engine sample RAM with M streamed samples, runs
//               one engine pass, reports completion and repeats.
//               Optional engine timeout: define NEO_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module neo_frame_sequencer
    import neo_pkg::*;
#(
    parameter int N     = 16,
    parameter int M     = 32,
    parameter int CNT_W = 16
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    s_valid,
    input  logic signed [N-1:0]     s_data,
    output logic                    s_ready,
    output logic                    mem_we,
    output logic [$clog2(M)-1:0]    mem_waddr,
    output logic signed [N-1:0]     mem_wdata,
    output logic                    eng_rst_n,
    input  logic                    eng_ready,
    output logic                    busy,
    output logic                    frame_done,
    output logic [CNT_W-1:0]        frame_cnt,
    output logic                    err
);

    localparam int             AW          = $clog2(M);
    localparam int             FW          = $clog2(M) + 1;
    localparam logic [FW-1:0]  c_fill_last = FW'(M - 1);

    neo_seq_state_t r_state;
    neo_seq_state_t w_next;
    logic [FW-1:0]  r_fill_cnt;
    logic           w_accept;

    // All handshake/gating outputs decode the state register directly
    assign s_ready    = (r_state == FILL);
    assign w_accept   = s_valid && s_ready;
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == DONE);
    assign eng_rst_n  = (r_state == RUN) || (r_state == DONE);

`ifdef NEO_TIMEOUT_EN
    logic w_timeout;

    neo_run_watchdog #(
        .M (M)
    ) u_run_watchdog (
        .Clk     (Clk),
        .reset   (reset),
        .clear   (r_state != RUN),
        .enable  (r_state == RUN),
        .timeout (w_timeout)
    );

    assign err = (r_state == ERR);
`else
    assign err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (enable) w_next = FILL;
            end
            FILL: begin
                if (w_accept && (r_fill_cnt == c_fill_last)) w_next = KICK;
            end
            KICK: begin
                w_next = RUN;
            end
            RUN: begin
                if (eng_ready) begin
                    w_next = DONE;
`ifdef NEO_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_next = ERR;
`endif
                end
            end
            DONE: begin
                w_next = enable ? FILL : IDLE;
            end
`ifdef NEO_TIMEOUT_EN
            ERR: begin
                w_next = ERR;
            end
`endif
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fill_cnt <= '0;
            mem_we     <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            frame_cnt  <= '0;
        end else begin
            r_state <= w_next;
            mem_we  <= w_accept;
            if (w_accept) begin
                mem_waddr <= r_fill_cnt[AW-1:0];
                mem_wdata <= s_data;
            end
            // Outside FILL the count is parked at zero so every frame starts at address 0
            if (r_state != FILL) begin
                r_fill_cnt <= '0;
            end else if (w_accept) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end
            if ((r_state == RUN) && eng_ready) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
